logic_fu_pipe: RTL

- Parametrised, pipelined bitwise logic functional unit for the out-of-order core's execute cluster. Successor to the fixed 64-bit single-function NOR array.
- Selects one of eight bitwise ops per instruction. Carries a ROB/physical-destination tag through the pipe.
- Valid/ready handshake on input and output, with a flush for mispredict recovery.
- Produces a result plus a zero flag for the writeback/CDB arbiter.

---
 rtl/logic_fu_pipe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/logic_fu_pipe.sv
// rtl/logic_fu_pipe.sv - pipelined bitwise logic functional unit with tag, zero flag and valid/ready handshake
//
// Purpose:
//   Executes one of eight bitwise ops per instruction and carries the ROB /
//   physical-destination tag through a STAGES-deep elastic pipeline. The op
//   and zero flag are computed in front of stage 0; later stages only delay.
//   Bubbles compress under a downstream stall, and flush kills every
//   in-flight op at the next rising edge.
//
// Optional feature (macro LOGIC_FU_POPCNT_EN):
//   When defined, stage 0 also captures the population count of the result,
//   and that count travels with the op to out_popcnt. When undefined,
//   out_popcnt is tied to 0 and no popcount logic is built.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   flush       in   synchronous kill of all in-flight ops
//   in_valid    in   input op valid
//   in_ready    out  unit can accept an op this cycle
//   in_op       in   op select: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 ANDN, 7 ORN
//   in_a        in   operand A
//   in_b        in   operand B
//   in_tag      in   instruction tag
//   out_valid   out  result valid
//   out_ready   in   consumer accepts result
//   out_result  out  result
//   out_zero    out  1 when out_result == 0 (0 while out_valid is 0)
//   out_tag     out  tag of result
//   out_popcnt  out  population count of out_result (0 without the feature)
module logic_fu_pipe #(
    parameter int WIDTH  = 64,
    parameter int TAG_W  = 6,
    parameter int STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_op,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_result,
    output logic                         out_zero,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(WIDTH+1)-1:0]   out_popcnt
);

    localparam int PCW  = $clog2(WIDTH + 1);
    localparam int LAST = STAGES - 1;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_ORN  = 3'd7
    } op_e;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  result_q [STAGES];
    logic [STAGES-1:0] zero_q;
    logic [TAG_W-1:0]  tag_q    [STAGES];

    logic [WIDTH-1:0]  op_result;
    logic              op_zero;
    logic              accept;

    // Stage k may load when it is empty or drains into k+1, which recursively
    // unrolls to: out_ready, or any empty stage from k to the last. Written in
    // closed form so the per-stage terms do not chain through each other.
    for (genvar k = 0; k < STAGES; k++) begin : g_load
        assign load[k] = out_ready | ~(&valid_q[LAST:k]);
    end

    assign in_ready = load[0] & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        op_result = '0;
        case (op_e'(in_op))
            OP_AND:  op_result = in_a & in_b;
            OP_OR:   op_result = in_a | in_b;
            OP_XOR:  op_result = in_a ^ in_b;
            OP_NOR:  op_result = ~(in_a | in_b);
            OP_NAND: op_result = ~(in_a & in_b);
            OP_XNOR: op_result = ~(in_a ^ in_b);
            OP_ANDN: op_result = in_a & ~in_b;
            OP_ORN:  op_result = in_a | ~in_b;
            default: op_result = '0;
        endcase
    end

    assign op_zero = ~|op_result;

    // A stage that cannot load is necessarily full and holding, so keeping its
    // valid bit is correct; a loading stage inherits its predecessor's valid.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (load[0]) begin
                valid_d[0] = accept;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_d[k] = valid_q[k-1];
                end
            end
        end
    end

    // Data registers only move when carrying a live op, so idle stages keep
    // their last contents instead of sampling undriven inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            zero_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                result_q[k] <= '0;
                tag_q[k]    <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                result_q[0] <= op_result;
                zero_q[0]   <= op_zero;
                tag_q[0]    <= in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k] && valid_q[k-1]) begin
                    result_q[k] <= result_q[k-1];
                    zero_q[k]   <= zero_q[k-1];
                    tag_q[k]    <= tag_q[k-1];
                end
            end
        end
    end

    assign out_valid  = valid_q[LAST];
    assign out_result = result_q[LAST];
    assign out_zero   = valid_q[LAST] & zero_q[LAST];
    assign out_tag    = tag_q[LAST];

`ifdef LOGIC_FU_POPCNT_EN
    logic [PCW-1:0] pop_q [STAGES];
    logic [PCW-1:0] op_pop;

    always_comb begin
        op_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            op_pop = op_pop + PCW'(op_result[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                pop_q[k] <= '0;
            end
        end else begin
            if (accept) begin
                pop_q[0] <= op_pop;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k] && valid_q[k-1]) begin
                    pop_q[k] <= pop_q[k-1];
                end
            end
        end
    end

    assign out_popcnt = pop_q[LAST];
`else
    assign out_popcnt = '0;
`endif

endmodule
